// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: op codes, FSM states and fixed result patterns.
package alu_pkg;

    localparam logic [2:0] OP_ADD     = 3'd0;
    localparam logic [2:0] OP_ADD_ALT = 3'd1;
    localparam logic [2:0] OP_XOR_OR  = 3'd2;
    localparam logic [2:0] OP_ANY     = 3'd3;
    localparam logic [2:0] OP_ALL     = 3'd4;
    localparam logic [2:0] OP_SHL     = 3'd5;
    localparam logic [2:0] OP_MUL     = 3'd6;
    localparam logic [2:0] OP_ZERO    = 3'd7;

    localparam logic [7:0] RES_ANY = 8'h81;
    localparam logic [7:0] RES_ALL = 8'h7E;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational ALU for every op except multiply, which the scheduler sequences.
module alu_core
    import alu_pkg::*;
(
    input  logic [2:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] result
);

    logic [3:0] shl;

    always_comb begin
        shl    = b << a;
        result = 8'h00;
        case (op)
            OP_ADD, OP_ADD_ALT: result = {3'b000, {1'b0, a} + {1'b0, b}};
            OP_XOR_OR:          result = {a ^ b, a | b};
            OP_ANY:             result = (|{a, b}) ? RES_ANY : 8'h00;
            OP_ALL:             result = (&{a, b}) ? RES_ALL : 8'h00;
            OP_SHL:             result = {4'h0, shl};
            OP_ZERO:            result = 8'h00;
            default:            result = 8'h00;
        endcase
    end

endmodule

// File: rtl/alu_scheduler.sv
// Two-requester round-robin front end for a small ALU with a 4-cycle shift-add multiplier
// and a valid/ready response port.
module alu_scheduler
    import alu_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [2:0] req0_op,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [2:0] req1_op,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_data,
    output logic       resp_id,
    output logic       busy,
    output logic [7:0] done_count
);

    state_t     state_reg, state_next;
    logic       prio_reg;
    logic [2:0] op_reg;
    logic [3:0] a_reg, b_reg;
    logic       id_reg;
    logic [1:0] cnt_reg;
    logic [7:0] acc_reg;
    logic       resp_valid_reg;
    logic [7:0] resp_data_reg;
    logic [7:0] done_count_reg;

    logic       grant0, grant1, accept, exec_last, handshake;
    logic [7:0] core_result, mul_term, mul_sum;

    alu_core u_core (
        .op     (op_reg),
        .a      (a_reg),
        .b      (b_reg),
        .result (core_result)
    );

    // prio_reg names the requester that wins when both are valid
    assign grant0     = req0_valid && (!req1_valid || !prio_reg);
    assign grant1     = req1_valid && (!req0_valid || prio_reg);
    assign req0_ready = !reset && (state_reg == IDLE) && grant0;
    assign req1_ready = !reset && (state_reg == IDLE) && grant1;
    assign accept     = (req0_ready && req0_valid) || (req1_ready && req1_valid);

    assign exec_last  = (op_reg != OP_MUL) || (cnt_reg == 2'd3);
    assign handshake  = resp_valid_reg && resp_ready;
    assign mul_term   = b_reg[cnt_reg] ? ({4'h0, a_reg} << cnt_reg) : 8'h00;
    assign mul_sum    = acc_reg + mul_term;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)    state_next = EXEC;
            EXEC:    if (exec_last) state_next = RESP;
            RESP:    if (handshake) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prio_reg       <= 1'b0;
            op_reg         <= 3'd0;
            a_reg          <= 4'd0;
            b_reg          <= 4'd0;
            id_reg         <= 1'b0;
            cnt_reg        <= 2'd0;
            acc_reg        <= 8'd0;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= 8'd0;
            done_count_reg <= 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg   <= grant1 ? req1_op : req0_op;
                        a_reg    <= grant1 ? req1_a  : req0_a;
                        b_reg    <= grant1 ? req1_b  : req0_b;
                        id_reg   <= grant1;
                        prio_reg <= !grant1;
                        cnt_reg  <= 2'd0;
                        acc_reg  <= 8'd0;
                    end
                end
                EXEC: begin
                    if (op_reg == OP_MUL) begin
                        acc_reg <= mul_sum;
                        cnt_reg <= cnt_reg + 2'd1;
                    end
                    if (exec_last)
                        resp_data_reg <= (op_reg == OP_MUL) ? mul_sum : core_result;
                end
                RESP: begin
                    // first RESP cycle presents the latched result; valid then holds until taken
                    if (!resp_valid_reg) begin
                        resp_valid_reg <= 1'b1;
                    end else if (resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        done_count_reg <= done_count_reg + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_valid = resp_valid_reg;
    assign resp_data  = resp_data_reg;
    assign resp_id    = id_reg;
    assign busy       = (state_reg != IDLE);
    assign done_count = done_count_reg;

endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 Parameters: none; all widths are fixed (operands 4 bits, result 8 bits, op 3 bits).
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset; clears all state immediately on assertion.
REQ-004 req0_valid / req1_valid  input  1  requester 0/1 presents an operation.
REQ-005 req0_ready / req1_ready  output  1  the request is accepted when it is high in the same cycle as the matching valid.
REQ-006 req0_op / req1_op  input  3  operation code (encodings in REQ-013).
REQ-007 req0_a, req0_b / req1_a, req1_b  input  4 each  operands A and B.
REQ-008 resp_valid  output  1  a result is presented.
REQ-009 resp_ready  input  1  the consumer accepts the result.
REQ-010 resp_data  output  8  result; resp_id  output  1  index of the requester that owns the result.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 done_count  output  8  number of completed response handshakes; wraps from 255 to 0.

Function
REQ-013 Op codes:
- 0, 1: zero-extended 5-bit A+B.
- 2: {A^B, A|B}.
- 3: 8'h81 if |{A,B}, else 0.
- 4: 8'h7E if &{A,B}, else 0.
- 5: {4'h0, (B<<A)[3:0]}.
- 6: A*B (8-bit product).
- 7: 8'h00.
REQ-014 FSM states: IDLE, EXEC, RESP.
- IDLE->EXEC on any accepted request.
- EXEC->RESP when the computation completes.
- RESP->IDLE on resp_valid && resp_ready.
REQ-015 req_ready is asserted only in IDLE, for the granted requester only; at most one ready is high per cycle.
REQ-016 Arbitration is round-robin.
- If both valids are high in IDLE, grant the requester not granted last.
- If only one valid is high, grant it regardless of the pointer.
- The pointer updates only on acceptance.
- After reset the pointer favours requester 0.
REQ-017 On acceptance, op, A, B and the requester id are captured into internal registers; later input changes do not affect the transaction.
REQ-018 Ops other than 6 spend exactly 1 cycle in EXEC; resp_valid rises 2 cycles after the accepting edge.
REQ-019 Op 6 uses a sequential shift-add over 4 EXEC cycles (one B bit per cycle, LSB first, with a 2-bit counter); resp_valid rises 5 cycles after the accepting edge.
REQ-020 In RESP, resp_data and resp_id are held stable until the handshake completes; resp_valid is never withdrawn without a handshake.
REQ-021 done_count increments by 1 on each response handshake; 8'hFF+1 gives 8'h00.
REQ-022 No request is accepted in EXEC or RESP; a valid held across those states is granted in the next IDLE cycle.
REQ-023 resp_ready without resp_valid has no effect; a request valid during the RESP handshake cycle is not accepted until the following IDLE cycle.

Reset
REQ-024 On reset assertion, all of the following are cleared asynchronously; any in-flight transaction is discarded without a response:
- state = IDLE.
- req0_ready = req1_ready = 0.
- resp_valid = 0, resp_data = 0, resp_id = 0.
- busy = 0, done_count = 0.
- round-robin pointer favours requester 0; multiply counter and accumulator = 0.
REQ-025 After reset deasserts, the first rising edge treats the block as IDLE.

Structure
REQ-026 Shared package alu_pkg holds:
- op code localparams;
- the state enum (IDLE/EXEC/RESP);
- result constants 8'h81 and 8'h7E.
REQ-027 One combinational sub-module, alu_core, computes ops 0-5 and 7 from the captured A, B and op.
REQ-028 The op 6 shift-add sequencing, the arbitration and the FSM live in alu_scheduler.

Verification
REQ-029 Single request, op 0:
- Stimulus: reset, then req0 op=0, A=4'hF, B=4'h1.
- Response: resp_data=8'h10, resp_id=0, resp_valid 2 cycles after acceptance.
REQ-030 Multiply:
- Stimulus: req1 op=6, A=4'hF, B=4'hF, resp_ready held high.
- Response: resp_data=8'hE1, resp_id=1, resp_valid exactly 5 cycles after acceptance, busy high throughout.
REQ-031 Contention:
- Stimulus: both valids held high with op=2, A=4'h5, B=4'hA.
- Response: grants alternate 0,1,0,1; each resp_data=8'hFF.
REQ-032 Backpressure:
- Stimulus: op=3, A=0, B=0; resp_ready low for 10 cycles.
- Response: resp_valid and resp_data=8'h00 held stable; req0_ready and req1_ready stay low; done_count unchanged until the handshake.
REQ-033 Reset during multiply:
- Stimulus: assert reset in the 2nd EXEC cycle of op 6.
- Response: resp_valid=0 and busy=0 immediately; no response is ever produced; done_count=0.
REQ-034 Wrap and boundary ops:
- 256 handshakes return done_count to 8'h00.
- op 5 with A=4'h3, B=4'h3 gives 8'h08.
- op 4 with A=B=4'hF gives 8'h7E.
- op 7 gives 8'h00.
